// File: rtl/rotary_pkg.sv
// Shared types and constants for the synthetic quadrature encoder generator.
// The gray table lists the CW walk; CCW walks the same table backwards.
package rotary_pkg;

    typedef enum logic [1:0] {
        ROT_CW  = 2'b00,
        ROT_CCW = 2'b01,
        PRESS   = 2'b10,
        NOP     = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROTATE,
        ST_PRESS,
        ST_FINISH
    } state_t;

    localparam int POS_W = 3;

    // Entries are {A,B}: 00 -> 10 -> 11 -> 01 for clockwise rotation.
    localparam logic [1:0] GRAY_CW [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [1:0] gray_ab(input logic [1:0] phase, input logic ccw);
        logic [1:0] idx;
        idx = ccw ? (2'd0 - phase) : phase;
        return GRAY_CW[idx];
    endfunction

endpackage

// File: rtl/quadrature_generator_phase_timer.sv
// Free-running divider giving a one-cycle tick every PERIOD cycles.
// A restart realigns it so the first tick lands PERIOD cycles after the restart edge.
module phase_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/quadrature_generator.sv
// Command-driven quadrature encoder emulator: walks A/B through gray phases,
// holds the button for press commands and tracks the position a decoder should read.
module quadrature_generator
    import rotary_pkg::*;
#(
    parameter int CLK_PER_QUARTER = 1000,
    parameter int BTN_HOLD        = 10000,
    parameter int STEP_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              signal_a,
    output logic              signal_b,
    output logic              button,
    output logic              busy,
    output logic              done,
    output logic [2:0]        expected_position
);

    state_t             state;
    state_t             state_nxt;
    op_t                op_in;
    logic               accept;
    logic               ccw;
    logic [1:0]         phase;
    logic [1:0]         phase_nxt;
    logic [1:0]         ab_nxt;
    logic [STEP_W-1:0]  detents;
    logic [POS_W-1:0]   position;
    logic               quarter_tick;
    logic               hold_tick;
    logic               step_en;
    logic               is_rotate;

    assign op_in     = op_t'(cmd_op);
    assign is_rotate = (op_in == ROT_CW) || (op_in == ROT_CCW);
    assign cmd_ready = (state == ST_IDLE) || (state == ST_FINISH);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = ~cmd_ready;
    assign done      = (state == ST_FINISH);
    assign expected_position = position;

    phase_timer #(.PERIOD(CLK_PER_QUARTER)) u_quarter_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .tick    (quarter_tick)
    );

    phase_timer #(.PERIOD(BTN_HOLD)) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .tick    (hold_tick)
    );

    // FINISH accepts like IDLE, so a new command can follow with no dead cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FINISH: begin
                state_nxt = ST_IDLE;
                if (cmd_valid) begin
                    if (is_rotate && (cmd_steps != '0)) begin
                        state_nxt = ST_ROTATE;
                    end else if (op_in == PRESS) begin
                        state_nxt = ST_PRESS;
                    end else begin
                        state_nxt = ST_FINISH;
                    end
                end
            end
            ST_ROTATE: begin
                if (detents == '0) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_PRESS: begin
                if (!button) begin
                    state_nxt = ST_FINISH;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign step_en   = (state == ST_ROTATE) && (detents != '0) && quarter_tick;
    assign phase_nxt = phase + 2'd1;
    assign ab_nxt    = gray_ab(phase_nxt, ccw);

    // A/B, button and position are all registered so the outputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccw      <= 1'b0;
            phase    <= 2'd0;
            detents  <= '0;
            signal_a <= 1'b0;
            signal_b <= 1'b0;
            button   <= 1'b0;
            position <= '0;
        end else if (accept) begin
            ccw     <= (op_in == ROT_CCW);
            detents <= is_rotate ? cmd_steps : '0;
            phase   <= 2'd0;
            button  <= (op_in == PRESS);
        end else if (step_en) begin
            phase    <= phase_nxt;
            signal_a <= ab_nxt[1];
            signal_b <= ab_nxt[0];
            if (!signal_a && ab_nxt[1]) begin
                position <= ccw ? (position - POS_W'(1)) : (position + POS_W'(1));
            end
            if (phase == 2'd3) begin
                detents <= detents - STEP_W'(1);
            end
        end else if ((state == ST_PRESS) && hold_tick) begin
            button <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quadrature_generator.sv
// Bench for quadrature_generator: table-driven commands, random commands and reset corner cases,
// all compared cycle by cycle against a timeline model derived from the command rules.
module tb_quadrature_generator;

    localparam int Q  = 4;
    localparam int H  = 5;
    localparam int SW = 8;
    localparam logic [8:0] RESET_OUTS = 9'b000_0_1_0_000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [SW-1:0] cmd_steps = '0;
    logic          cmd_ready;
    logic          signal_a;
    logic          signal_b;
    logic          button;
    logic          busy;
    logic          done;
    logic [2:0]    expected_position;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] pos_ref = 3'd0;

    always #5 clk = ~clk;

    quadrature_generator #(
        .CLK_PER_QUARTER (Q),
        .BTN_HOLD        (H),
        .STEP_W          (SW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_steps         (cmd_steps),
        .signal_a          (signal_a),
        .signal_b          (signal_b),
        .button            (button),
        .busy              (busy),
        .done              (done),
        .expected_position (expected_position)
    );

    typedef struct {
        logic [1:0] op;
        int         steps;
        int         gap;
        int         exp_done;
        logic [2:0] exp_pos;
    } vec_t;

    vec_t vt [10];

    function automatic logic [8:0] outs();
        return {signal_a, signal_b, button, done, cmd_ready, busy, expected_position};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got=%0h required=%0h (a,b,btn,done,rdy,busy,pos packing for traces)",
                     name, idx, act, exp);
        end
    endtask

    // Cycle t is the cycle after edge T0+t, T0 being the accepting edge.
    function automatic int model_last(input logic [1:0] op, input int steps);
        if (op <= 2'd1 && steps != 0) return 4 * steps * Q + 1;
        if (op == 2'd2) return H + 1;
        return 0;
    endfunction

    function automatic logic [8:0] model(input logic [1:0] op, input int steps, input int t,
                                         input logic [2:0] p0);
        int   last, k, n, r, pos;
        logic a, b, btn, dn;
        a = 1'b0; b = 1'b0; btn = 1'b0; pos = p0;
        last = model_last(op, steps);
        if (op <= 2'd1 && steps != 0) begin
            k = t / Q;
            if (k > 4 * steps) k = 4 * steps;
            if (k < 4 * steps) begin
                case (k % 4)
                    1: {a, b} = (op == 2'd0) ? 2'b10 : 2'b01;
                    2: {a, b} = 2'b11;
                    3: {a, b} = (op == 2'd0) ? 2'b01 : 2'b10;
                    default: {a, b} = 2'b00;
                endcase
            end
            r = (op == 2'd0) ? 1 : 2;
            n = (k >= r) ? (k - r) / 4 + 1 : 0;
            pos = ((op == 2'd0) ? (p0 + n) : (p0 + 8 * steps - n)) % 8;
        end else if (op == 2'd2) begin
            btn = (t < H);
        end
        dn = (t == last);
        return {a, b, btn, dn, dn, ~dn, 3'(pos)};
    endfunction

    task automatic idle_check(input int idx);
        @(negedge clk);
        chk("idle", idx, outs(), {6'b000_0_1_0, pos_ref});
    endtask

    task automatic issue(input logic [1:0] op, input int steps);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_steps = SW'(steps);
        chk("accept_ready", steps, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_steps = SW'($urandom);
    endtask

    task automatic follow(input logic [1:0] op, input int steps, output int done_t);
        int         last;
        logic [8:0] fin;
        last   = model_last(op, steps);
        done_t = -1;
        for (int t = 0; t <= last; t++) begin
            if (t > 0) @(negedge clk);
            chk("trace", t, outs(), model(op, steps, t, pos_ref));
            if (done && done_t < 0) done_t = t;
        end
        fin     = model(op, steps, last, pos_ref);
        pos_ref = fin[2:0];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int dt;
        logic [1:0] rop;
        int rsteps;

        vt[0] = '{2'd0, 3, 1, 49, 3'd3};
        vt[1] = '{2'd1, 3, 0, 49, 3'd0};
        vt[2] = '{2'd1, 1, 2, 17, 3'd7};
        vt[3] = '{2'd0, 1, 0, 17, 3'd0};
        vt[4] = '{2'd2, 77, 1, 6, 3'd0};
        vt[5] = '{2'd3, 9, 0, 0, 3'd0};
        vt[6] = '{2'd0, 0, 0, 0, 3'd0};
        vt[7] = '{2'd1, 0, 1, 0, 3'd0};
        vt[8] = '{2'd0, 8, 1, 129, 3'd0};
        vt[9] = '{2'd1, 8, 0, 129, 3'd0};

        #2;
        chk("reset_outs", 0, outs(), RESET_OUTS);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(0);

        for (int i = 0; i < 10; i++) begin
            for (int g = 0; g < vt[i].gap; g++) idle_check(i);
            issue(vt[i].op, vt[i].steps);
            follow(vt[i].op, vt[i].steps, dt);
            chk("done_latency", i, dt, vt[i].exp_done);
            chk("end_pos", i, {29'd0, expected_position}, {29'd0, vt[i].exp_pos});
        end

        for (int i = 0; i < 20; i++) begin
            rop    = 2'($urandom_range(0, 3));
            rsteps = $urandom_range(0, 4);
            for (int g = 0; g < $urandom_range(0, 2); g++) idle_check(100 + i);
            issue(rop, rsteps);
            follow(rop, rsteps, dt);
        end

        // Reset in the middle of a rotation while A=B=1.
        idle_check(200);
        issue(2'd0, 2);
        repeat (2 * Q) @(negedge clk);
        chk("pre_reset_ab", 2 * Q, {30'd0, signal_a, signal_b}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 0, outs(), RESET_OUTS);
        pos_ref   = 3'd0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_steps = SW'(1);
        @(negedge clk);
        chk("held_in_reset", 1, outs(), RESET_OUTS);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        follow(2'd0, 1, dt);
        chk("post_reset_latency", 0, dt, 17);
        idle_check(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
